ppu_vram_arbiter: RTL

- Parametrised VRAM access arbiter between the CPU-side PPU register path and the background/sprite renderer.
- Replaces the plain vblank address mux with:
  - a posted-write FIFO that absorbs CPU writes while rendering is active;
  - an ordered drain of those writes at vblank;
  - a handshaked CPU read path that stalls until the bus is safe.
- Sits between the register interface, the renderer and the synchronous VRAM.

---
 rtl/ppu_vram_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter
// ----------------------------------------------------------------------------
// Arbitrates the synchronous VRAM port between the CPU-side PPU register path
// and the background/sprite renderer.
//   * CPU writes are posted into a small FIFO. They are accepted at any time
//     and acknowledged one cycle after acceptance.
//   * Queued writes drain in order, one per cycle, while the bus is owned by
//     the CPU side (vblank).
//   * CPU reads wait until the bus is CPU-owned and the FIFO is empty. A read
//     therefore always observes every earlier posted write.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   show_bg, vc         rendering enable and current scanline (ownership source)
//   cpu_req/we/addr/wdata, cpu_ack, cpu_rdata
//                       CPU request/acknowledge handshake
//   render_addr, render_rdata
//                       renderer fetch address and returned data
//   mem_addr/we/wdata, mem_rdata
//                       VRAM port (read data has one cycle of latency)
//   vblank              registered bus-ownership flag (1 = CPU side owns bus)
//   fifo_level          posted-write FIFO occupancy
// ----------------------------------------------------------------------------
module ppu_vram_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WFIFO_DEPTH = 4,
    parameter int unsigned LINE_W      = 10,
    parameter int unsigned VBLANK_LINE = 281,
    localparam int unsigned PTR_W      = $clog2(WFIFO_DEPTH),
    localparam int unsigned LVL_W      = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              show_bg,
    input  logic [LINE_W-1:0] vc,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [ADDR_W-1:0] render_addr,
    output logic [DATA_W-1:0] render_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vblank,
    output logic [LVL_W-1:0]  fifo_level
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              vblank_r;
    logic              vblank_nxt_s;
    logic              cpu_ack_r;
    logic [DATA_W-1:0] rdata_r;

    logic [ADDR_W-1:0] fifo_addr_r [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_r [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;

    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              pop_s;
    logic              push_s;
    logic              rd_issue_s;

    assign fifo_empty_s = (level_r == {LVL_W{1'b0}});
    assign fifo_full_s  = (level_r == LVL_W'(WFIFO_DEPTH));

    // The head entry is written to VRAM in every CPU-owned cycle that has one.
    assign pop_s = vblank_r & ~fifo_empty_s;

    // A full FIFO still accepts a write in a cycle that pops, because the
    // popped slot is the one the new entry lands in.
    assign push_s = cpu_req & cpu_we & ~cpu_ack_r & (state_r == ST_IDLE)
                  & (~fifo_full_s | pop_s);

    // Reads issue only when nothing is queued, so they see all posted writes.
    assign rd_issue_s = cpu_req & ~cpu_we & ~cpu_ack_r & (state_r == ST_IDLE)
                      & vblank_r & fifo_empty_s;

    assign vblank_nxt_s = ~show_bg | (vc >= LINE_W'(VBLANK_LINE));

    // Bus ownership flag, one cycle behind show_bg/vc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank_r <= 1'b1;
        end else begin
            vblank_r <= vblank_nxt_s;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_issue_s) begin
                    state_nxt_s = ST_RD_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_ADDR: state_nxt_s = ST_RD_DATA;
            ST_RD_DATA: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Acknowledge pulse: one cycle after a write is accepted, or in RD_DATA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack_r <= 1'b0;
        end else begin
            cpu_ack_r <= push_s | (state_r == ST_RD_ADDR);
        end
    end

    // Holds the last read result after the acknowledge cycle has passed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_RD_DATA) begin
            rdata_r <= mem_rdata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage; the entries are cleared so no stale data survives a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(WFIFO_DEPTH); i++) begin
                fifo_addr_r[i] <= {ADDR_W{1'b0}};
                fifo_data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= cpu_addr;
            fifo_data_r[wr_ptr_r] <= cpu_wdata;
        end
    end

    // VRAM address/write mux. RD_ADDR keeps the CPU address even if
    // ownership drops in that cycle, so the issued read still completes.
    always_comb begin
        mem_addr = cpu_addr;
        mem_we   = 1'b0;
        if (state_r == ST_RD_ADDR) begin
            mem_addr = cpu_addr;
        end else if (!vblank_r) begin
            mem_addr = render_addr;
        end else if (!fifo_empty_s) begin
            mem_addr = fifo_addr_r[rd_ptr_r];
            mem_we   = 1'b1;
        end else begin
            mem_addr = cpu_addr;
        end
    end

    assign mem_wdata    = fifo_data_r[rd_ptr_r];
    assign render_rdata = mem_rdata;
    assign vblank       = vblank_r;
    assign fifo_level   = level_r;
    assign cpu_ack      = cpu_ack_r;
    // Read data appears in the acknowledge cycle itself, then is held.
    assign cpu_rdata    = (state_r == ST_RD_DATA) ? mem_rdata : rdata_r;

endmodule
